// File: rtl/clk_en_pkg.sv
// Shared constants and helpers for the clock-enable generator.
// The divisor constants assume the 100 MHz system clock. DIV_1HZ needs
// 27 bits, which is why WIDTH defaults to 27.
package clk_en_pkg;

    localparam int DIV_25MHZ  = 4;
    localparam int DIV_500KHZ = 200;
    localparam int DIV_1KHZ   = 100000;
    localparam int DIV_1HZ    = 100000000;

    // Width of a channel index. It is at least one bit so that a
    // single-channel build still has a legal select port.
    function automatic int chWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel. It holds its own divisor, a free-running counter,
// and registered tick and square-wave flops.
// A load or a restart parks the counter at zero and clears both outputs in
// the same edge. Because of this, a divisor change can never emit a runt
// tick.
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int WIDTH       = 27,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic [WIDTH-1:0] div_o
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [WIDTH-1:0] half;

    // Next-state logic: wrap at div-1, raise the square wave once the
    // counter reaches the upper half, and let load/restart override.
    always_comb begin
        half   = div_q >> 1;
        div_d  = div_q;
        cnt_d  = '0;
        tick_d = 1'b0;
        if (div_q != '0) begin
            if (cnt_q == div_q - ONE) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + ONE;
            end
        end
        sq_d = (div_q != '0) && (cnt_d >= half);
        if (load_i) begin
            div_d = load_val_i;
        end
        if (load_i || restart_i) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            sq_d   = 1'b0;
        end
    end

    // Channel state registers. Reset returns the divisor to its default.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= RESET_DIV;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign div_o  = div_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator. This level only does three things:
// it decodes divisor writes, fans the sync strobe out to every channel, and
// packs the channel outputs. All timing state lives in clk_en_chan.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 27,
    parameter int DEFAULT_DIV = 4,
    parameter int CH_W        = chWidth(CHANNELS)
) (
    input  logic                      clk_100mhz,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [WIDTH-1:0]          wr_div,
    input  logic                      sync_i,
    output logic [CHANNELS-1:0]       tick_o,
    output logic [CHANNELS-1:0]       sq_o,
    output logic [CHANNELS*WIDTH-1:0] div_o
);

    logic [CHANNELS-1:0] loadVec;

    // Write decode. An index at or above CHANNELS matches no channel, so
    // such a write is dropped without side effects.
    always_comb begin
        loadVec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            loadVec[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_en_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_100mhz (clk_100mhz),
            .rst_n      (rst_n),
            .load_i     (loadVec[i]),
            .load_val_i (wr_div),
            .restart_i  (sync_i),
            .tick_o     (tick_o[i]),
            .sq_o       (sq_o[i]),
            .div_o      (div_o[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen, built with three channels and a default
// divisor of 4. A per-cycle vector table covers the default cadence,
// divisors 0/1/3, an out-of-range write, and sync pulses. Hand-written
// sequences cover the long div-200 run, a write combined with sync, and an
// asynchronous reset.
module tb_clk_en_gen;

    localparam int CH = 3;
    localparam int W  = 27;

    logic              clk;
    logic              rstN;
    logic              wrEn;
    logic [1:0]        wrCh;
    logic [W-1:0]      wrDiv;
    logic              syncIn;
    logic [CH-1:0]     tickOut;
    logic [CH-1:0]     sqOut;
    logic [CH*W-1:0]   divOut;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic          wrEn;
        logic [1:0]    wrCh;
        logic [W-1:0]  wrDiv;
        logic          sync;
        logic [CH-1:0] expTick;
        logic [CH-1:0] expSq;
        logic [W-1:0]  expDiv1;
        logic [W-1:0]  expDiv2;
    } vecT;

    vecT vecs[$];

    clk_en_gen #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rstN),
        .wr_en      (wrEn),
        .wr_ch      (wrCh),
        .wr_div     (wrDiv),
        .sync_i     (syncIn),
        .tick_o     (tickOut),
        .sq_o       (sqOut),
        .div_o      (divOut)
    );

    // 100 MHz clock. Posedges fall at 5, 15, 25 ns and so on.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [80:0] actual,
                               input logic [80:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs from a negedge. Then wait for the next
    // negedge, so the outputs seen afterwards reflect exactly one posedge.
    task automatic applyStimulus(input logic en, input logic [1:0] ch,
                                 input logic [W-1:0] dv, input logic sy);
        wrEn   = en;
        wrCh   = ch;
        wrDiv  = dv;
        syncIn = sy;
        @(negedge clk);
    endtask

    task automatic addVec(input logic en, input logic [1:0] ch, input logic [W-1:0] dv,
                          input logic sy, input logic [CH-1:0] t, input logic [CH-1:0] s,
                          input logic [W-1:0] d1, input logic [W-1:0] d2);
        vecT v;
        v.wrEn = en; v.wrCh = ch; v.wrDiv = dv; v.sync = sy;
        v.expTick = t; v.expSq = s; v.expDiv1 = d1; v.expDiv2 = d2;
        vecs.push_back(v);
    endtask

    initial begin
        int tick0Count;
        int tick2Count;

        rstN = 1'b0; wrEn = 1'b0; wrCh = '0; wrDiv = '0; syncIn = 1'b0;

        // Default cadence: tick on every fourth edge, sq pattern 0,1,1,0.
        for (int r = 0; r < 3; r++) begin
            addVec(0, 0, 0, 0, 3'b000, 3'b000, 4, 4);
            addVec(0, 0, 0, 0, 3'b000, 3'b111, 4, 4);
            addVec(0, 0, 0, 0, 3'b000, 3'b111, 4, 4);
            addVec(0, 0, 0, 0, 3'b111, 3'b000, 4, 4);
        end
        // ch2 disabled with div=0.
        addVec(1, 2, 0, 0, 3'b000, 3'b000, 4, 0);
        addVec(0, 0, 0, 0, 3'b000, 3'b011, 4, 0);
        addVec(0, 0, 0, 0, 3'b000, 3'b011, 4, 0);
        addVec(0, 0, 0, 0, 3'b011, 3'b000, 4, 0);
        // ch2 at div=1: tick and sq held high.
        addVec(1, 2, 1, 0, 3'b000, 3'b000, 4, 1);
        addVec(0, 0, 0, 0, 3'b100, 3'b111, 4, 1);
        addVec(0, 0, 0, 0, 3'b100, 3'b111, 4, 1);
        addVec(0, 0, 0, 0, 3'b111, 3'b100, 4, 1);
        // ch2 at div=3: sq is 2 high, 1 low.
        addVec(1, 2, 3, 0, 3'b000, 3'b000, 4, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b111, 4, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b111, 4, 3);
        addVec(0, 0, 0, 0, 3'b111, 3'b000, 4, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b100, 4, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b111, 4, 3);
        addVec(0, 0, 0, 0, 3'b100, 3'b011, 4, 3);
        addVec(0, 0, 0, 0, 3'b011, 3'b100, 4, 3);
        // A write to channel 3 is out of range and must be ignored.
        addVec(1, 3, 7, 0, 3'b000, 3'b100, 4, 3);
        addVec(0, 0, 0, 0, 3'b100, 3'b011, 4, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b111, 4, 3);
        addVec(0, 0, 0, 0, 3'b011, 3'b100, 4, 3);
        // ch1 to div=8, out of phase with ch0. Then a one-cycle sync.
        addVec(1, 1, 8, 0, 3'b100, 3'b000, 8, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b101, 8, 3);
        addVec(0, 0, 0, 1, 3'b000, 3'b000, 8, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b100, 8, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b101, 8, 3);
        addVec(0, 0, 0, 0, 3'b100, 3'b001, 8, 3);
        addVec(0, 0, 0, 0, 3'b001, 3'b110, 8, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b110, 8, 3);
        addVec(0, 0, 0, 0, 3'b100, 3'b011, 8, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b111, 8, 3);
        addVec(0, 0, 0, 0, 3'b011, 3'b100, 8, 3);
        // Sync held for two cycles keeps everything parked.
        addVec(0, 0, 0, 1, 3'b000, 3'b000, 8, 3);
        addVec(0, 0, 0, 1, 3'b000, 3'b000, 8, 3);
        addVec(0, 0, 0, 0, 3'b000, 3'b100, 8, 3);

        // Reset state while rst_n is held low across several edges.
        repeat (3) @(negedge clk);
        checkOutput("reset_tick", 81'(tickOut), 81'(3'b000));
        checkOutput("reset_sq", 81'(sqOut), 81'(3'b000));
        checkOutput("reset_div", 81'(divOut), {27'd4, 27'd4, 27'd4});
        rstN = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wrEn, vecs[i].wrCh, vecs[i].wrDiv, vecs[i].sync);
            checkOutput($sformatf("vec%0d_tick", i), 81'(tickOut), 81'(vecs[i].expTick));
            checkOutput($sformatf("vec%0d_sq", i), 81'(sqOut), 81'(vecs[i].expSq));
            checkOutput($sformatf("vec%0d_div", i), 81'(divOut),
                        {vecs[i].expDiv2, vecs[i].expDiv1, 27'd4});
        end

        // Mid-count write of 200 to ch1. Going in, ch0 and ch2 are at count 1.
        applyStimulus(1, 1, 200, 0);
        checkOutput("div200_load_tick", 81'(tickOut[1]), 81'(0));
        checkOutput("div200_load_sq", 81'(sqOut[1]), 81'(0));
        checkOutput("div200_div", 81'(divOut), {27'd3, 27'd200, 27'd4});
        tick0Count = 0;
        tick2Count = 0;
        for (int k = 1; k <= 400; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("div200_tick_k%0d", k), 81'(tickOut[1]),
                        81'((k % 200) == 0));
            checkOutput($sformatf("div200_sq_k%0d", k), 81'(sqOut[1]),
                        81'((k % 200) >= 100));
            tick0Count += int'(tickOut[0]);
            tick2Count += int'(tickOut[2]);
        end
        checkOutput("ch0_undisturbed_ticks", 81'(tick0Count), 81'(100));
        checkOutput("ch2_undisturbed_ticks", 81'(tick2Count), 81'(134));

        // A write and a sync in the same cycle. ch0 becomes div 5, and
        // every channel restarts from zero.
        applyStimulus(1, 0, 5, 1);
        checkOutput("wrsync_tick", 81'(tickOut), 81'(3'b000));
        checkOutput("wrsync_sq", 81'(sqOut), 81'(3'b000));
        checkOutput("wrsync_div", 81'(divOut), {27'd3, 27'd200, 27'd5});
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrsync_e3_tick", 81'(tickOut), 81'(3'b100));
        checkOutput("wrsync_e3_sq", 81'(sqOut), 81'(3'b001));
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrsync_e4_tick", 81'(tickOut), 81'(3'b000));
        checkOutput("wrsync_e4_sq", 81'(sqOut), 81'(3'b101));
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrsync_e5_tick", 81'(tickOut), 81'(3'b001));
        checkOutput("wrsync_e5_sq", 81'(sqOut), 81'(3'b100));

        // Asynchronous reset in the low phase of the clock. The outputs
        // must clear before the next posedge arrives.
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_rst_tick", 81'(tickOut), 81'(3'b000));
        checkOutput("async_rst_sq", 81'(sqOut), 81'(3'b000));
        checkOutput("async_rst_div", 81'(divOut), {27'd4, 27'd4, 27'd4});
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("post_rst_tick_e%0d", k), 81'(tickOut),
                        81'((k == 4) ? 3'b111 : 3'b000));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
